cve2_mac_unit: RTL and testbench
================================

CVE2_MAC_UNIT -- requirements
Module: cve2_mac_unit

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning operand/accumulator width in bits.
REQ-002 SHALL have parameter Lanes, default 1, meaning SIMD lane count; legal values are 1, 2 or 4, and DataWidth % Lanes == 0.
REQ-003 SHALL have parameter NumAcc, default 4, meaning the number of internal accumulator registers (power of two, >=2).
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid_i, input, 1 bit: request valid.
REQ-007 SHALL have port req_ready_o, output, 1 bit: request accepted when high together with req_valid_i.
REQ-008 SHALL have port op_i, input, 2 bits: 00 MAC (acc+=a*b), 01 MSU (acc-=a*b), 10 CLR (acc=0), 11 RD (acc unchanged).
REQ-009 SHALL have port acc_sel_i, input, $clog2(NumAcc) bits: target accumulator index.
REQ-010 SHALL have port signed_i, input, 1 bit: lanes are two's-complement when 1, unsigned when 0.
REQ-011 SHALL have ports op_a_i and op_b_i, input, DataWidth bits each: packed lane operands, lane k at bits [k*W +: W], where W = DataWidth/Lanes.
REQ-012 SHALL have port rsp_valid_o, output, 1 bit, and port rsp_ready_i, input, 1 bit: response handshake.
REQ-013 SHALL have port rsp_data_o, output, DataWidth bits: accumulator value after the operation.
REQ-014 SHALL have port rsp_sat_o, output, Lanes bits: per-lane saturation-occurred flag for the response.

Function
REQ-015 SHALL implement a 2-stage pipeline: S1 registers the per-lane products; S2 is the response register.
REQ-016 SHALL give a latency of 2: a request accepted in cycle n drives rsp_valid_o high in cycle n+2 when there is no backpressure.
REQ-017 SHALL sustain a throughput of 1 request per cycle while rsp_ready_i is held high.
REQ-018 SHALL define stall = rsp_valid_o & ~rsp_ready_i.
REQ-019 SHALL drive req_ready_o = ~stall combinationally; S1 and S2 SHALL hold their contents while stall is high.
REQ-020 SHALL read the accumulator and write its update only on the cycle S1 advances into S2, so back-to-back requests to the same acc_sel_i see the previous result with no bubble.
REQ-021 SHALL compute each lane independently with no carry between lanes.
REQ-022 SHALL form the full 2W-bit product per lane (signed or unsigned per signed_i) and the sum/difference at 2W+1 bits before the width rule is applied.
REQ-023 SHALL, for RD, return the accumulator unchanged; for CLR, return 0 and write 0.
REQ-024 SHALL drive rsp_data_o, rsp_sat_o and rsp_valid_o stable while stall is high.
REQ-025 SHALL make a request accepted in the same cycle the S2 response is consumed enter S1 without loss.

Reset
REQ-026 SHALL, while rst_i is high, immediately clear all accumulators to 0, clear both stage valid bits, and drive rsp_data_o=0, rsp_sat_o=0 and rsp_valid_o=0.
REQ-027 SHALL discard in-flight requests on reset mid-operation, with no accumulator write.
REQ-028 SHALL present req_ready_o=1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with CVE2_MAC_SAT_EN defined, clamp each lane result to [-2^(W-1), 2^(W-1)-1] when signed or [0, 2^W-1] when unsigned, and set the matching rsp_sat_o bit when clamping occurs.
REQ-030 SHALL, without CVE2_MAC_SAT_EN, wrap each lane result modulo 2^W (low W bits), tie rsp_sat_o to 0, and synthesise no clamp logic.

Verification
REQ-031 SHALL cover: DataWidth=32, Lanes=1; MAC acc0 with a=3, b=5, then a=-2, b=4 signed, then RD -> responses 15, 7, 7 in cycles n+2, n+3, n+4.
REQ-032 SHALL cover: Lanes=4, unsigned, MAC a=0x02030405, b=0x01010102 -> rsp 0x0203040A, no inter-lane carry.
REQ-033 SHALL cover: acc1=0x7FFFFFFF, signed MAC a=1, b=1 -> with SAT_EN rsp 0x7FFFFFFF and sat=1; without SAT_EN rsp 0x80000000 and sat=0.
REQ-034 SHALL cover: rsp_ready_i held low 3 cycles with 3 requests issued -> req_ready_o low after S1 and S2 fill, rsp_data_o held, then all 3 responses delivered in order.
REQ-035 SHALL cover: rst_i asserted with 2 requests in flight to acc2 -> rsp_valid_o drops immediately, and a subsequent RD acc2 returns 0.

Source files
------------

// File: rtl/cve2_mac_unit.sv
// cve2_mac_unit: SIMD multiply-accumulate unit with a bank of internal accumulators.
// Two-stage pipeline. S1 holds the per-lane products. S2 holds the response.
// The accumulator is read and written only when S1 moves into S2, so back-to-back
// requests to the same accumulator always see the previous result.
// Optional feature macro: CVE2_MAC_SAT_EN. When it is defined, each lane result is
// clamped and flagged. When it is undefined, each lane result wraps modulo 2^W.
module cve2_mac_unit #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Lanes     = 1,
    parameter int unsigned NumAcc    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [1:0]                op_i,
    input  logic [$clog2(NumAcc)-1:0] acc_sel_i,
    input  logic                      signed_i,
    input  logic [DataWidth-1:0]      op_a_i,
    input  logic [DataWidth-1:0]      op_b_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DataWidth-1:0]      rsp_data_o,
    output logic [Lanes-1:0]          rsp_sat_o
);

    localparam int unsigned W    = DataWidth / Lanes;
    localparam int unsigned SelW = $clog2(NumAcc);

    typedef enum logic [1:0] {
        OpMac = 2'b00,
        OpMsu = 2'b01,
        OpClr = 2'b10,
        OpRd  = 2'b11
    } op_e;

    logic                             stall;
    logic                             s1_valid_q;
    op_e                              s1_op_q;
    logic [SelW-1:0]                  s1_sel_q;
    logic                             s1_signed_q;
    logic [Lanes-1:0][2*W-1:0]        s1_prod_q;
    logic [Lanes-1:0][2*W-1:0]        prod_d;
    logic [NumAcc-1:0][DataWidth-1:0] acc_q;
    logic [DataWidth-1:0]             result_d;
    logic [Lanes-1:0]                 sat_d;
    logic                             rsp_valid_q;
    logic [DataWidth-1:0]             rsp_data_q;

    // A full response that nobody takes freezes the whole pipe.
    assign stall       = rsp_valid_q & ~rsp_ready_i;
    assign req_ready_o = ~stall;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

    // Build the full 2W-bit product for each lane from sign- or zero-extended operands.
    always_comb begin
        logic [2*W-1:0] a_ext;
        logic [2*W-1:0] b_ext;
        prod_d = '0;
        a_ext  = '0;
        b_ext  = '0;
        for (int k = 0; k < Lanes; k++) begin
            a_ext     = {{W{signed_i & op_a_i[k*W+W-1]}}, op_a_i[k*W +: W]};
            b_ext     = {{W{signed_i & op_b_i[k*W+W-1]}}, op_b_i[k*W +: W]};
            prod_d[k] = a_ext * b_ext;
        end
    end

    // Combine the selected accumulator with the S1 products at 2W+1 bits.
    // Then reduce each lane back to W bits by clamping or by wrapping.
    always_comb begin
        logic [W-1:0] acc_lane;
        logic [2*W:0] acc_ext;
        logic [2*W:0] prod_ext;
        logic [2*W:0] sum;
        result_d = '0;
        sat_d    = '0;
        acc_lane = '0;
        acc_ext  = '0;
        prod_ext = '0;
        sum      = '0;
        for (int k = 0; k < Lanes; k++) begin
            acc_lane = acc_q[s1_sel_q][k*W +: W];
            acc_ext  = {{(W+1){s1_signed_q & acc_lane[W-1]}}, acc_lane};
            prod_ext = {s1_signed_q & s1_prod_q[k][2*W-1], s1_prod_q[k]};
            case (s1_op_q)
                OpMac:   sum = acc_ext + prod_ext;
                OpMsu:   sum = acc_ext - prod_ext;
                OpClr:   sum = '0;
                default: sum = acc_ext;
            endcase
`ifdef CVE2_MAC_SAT_EN
            if (s1_signed_q) begin
                if (!sum[2*W] && (sum[2*W-1:W-1] != '0)) begin
                    result_d[k*W +: W] = {1'b0, {(W-1){1'b1}}};
                    sat_d[k]           = 1'b1;
                end else if (sum[2*W] && (sum[2*W-1:W-1] != '1)) begin
                    result_d[k*W +: W] = {1'b1, {(W-1){1'b0}}};
                    sat_d[k]           = 1'b1;
                end else begin
                    result_d[k*W +: W] = sum[W-1:0];
                end
            end else begin
                if (sum[2*W]) begin
                    result_d[k*W +: W] = '0;
                    sat_d[k]           = 1'b1;
                end else if (sum[2*W-1:W] != '0) begin
                    result_d[k*W +: W] = '1;
                    sat_d[k]           = 1'b1;
                end else begin
                    result_d[k*W +: W] = sum[W-1:0];
                end
            end
`else
            result_d[k*W +: W] = sum[W-1:0];
`endif
        end
    end

    // Pipeline registers. Both stages advance together unless the response is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OpMac;
            s1_sel_q    <= '0;
            s1_signed_q <= 1'b0;
            s1_prod_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (!stall) begin
            s1_valid_q <= req_valid_i;
            if (req_valid_i) begin
                s1_op_q     <= op_e'(op_i);
                s1_sel_q    <= acc_sel_i;
                s1_signed_q <= signed_i;
                s1_prod_q   <= prod_d;
            end
            rsp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_q <= result_d;
            end
        end
    end

    // Commit the new accumulator value only when S1 moves into S2. RD leaves it untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (!stall && s1_valid_q && (s1_op_q != OpRd)) begin
            acc_q[s1_sel_q] <= result_d;
        end
    end

`ifdef CVE2_MAC_SAT_EN
    logic [Lanes-1:0] rsp_sat_q;

    // Per-lane clamp flags travel with the response data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_sat_q <= '0;
        end else if (!stall && s1_valid_q) begin
            rsp_sat_q <= sat_d;
        end
    end

    assign rsp_sat_o = rsp_sat_q;
`else
    assign rsp_sat_o = '0;
`endif

endmodule

// File: tb/tb_cve2_mac_unit.sv
// tb_cve2_mac_unit: self-checking bench for cve2_mac_unit.
// It drives two instances. Unit 0 uses Lanes=1. Unit 1 uses Lanes=4.
// The bench tracks the expected results of CVE2_MAC_SAT_EN when that macro is defined.
module tb_cve2_mac_unit;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        int          step;
        bit          lat;
    } exp_t;

    typedef struct {
        int          unit;
        logic [1:0]  op;
        logic [1:0]  sel;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expD;
        logic [3:0]  expS;
    } vec_t;

`ifdef CVE2_MAC_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid [2];
    logic        reqReady [2];
    logic [1:0]  opSel    [2];
    logic [1:0]  accSel   [2];
    logic        sgnSel   [2];
    logic [31:0] opA      [2];
    logic [31:0] opB      [2];
    logic        rspValid [2];
    logic        rspReady [2];
    logic [31:0] rspData  [2];
    logic        sat0;
    logic [3:0]  sat1;

    int          nVec = 0;
    int          nMis = 0;
    int          stepCnt = 0;
    logic [31:0] modelAcc [2][4];
    exp_t        q0 [$];
    exp_t        q1 [$];
    bit          useTab = 1'b0;
    bit          latFlag = 1'b0;
    logic [31:0] tabD = '0;
    logic [3:0]  tabS = '0;

    // The clock has a 10-unit period.
    always #5 clock = ~clock;

    cve2_mac_unit #(.DataWidth(32), .Lanes(1), .NumAcc(4)) dut0 (
        .clk_i(clock), .rst_i(reset),
        .req_valid_i(reqValid[0]), .req_ready_o(reqReady[0]),
        .op_i(opSel[0]), .acc_sel_i(accSel[0]), .signed_i(sgnSel[0]),
        .op_a_i(opA[0]), .op_b_i(opB[0]),
        .rsp_valid_o(rspValid[0]), .rsp_ready_i(rspReady[0]),
        .rsp_data_o(rspData[0]), .rsp_sat_o(sat0)
    );

    cve2_mac_unit #(.DataWidth(32), .Lanes(4), .NumAcc(4)) dut1 (
        .clk_i(clock), .rst_i(reset),
        .req_valid_i(reqValid[1]), .req_ready_o(reqReady[1]),
        .op_i(opSel[1]), .acc_sel_i(accSel[1]), .signed_i(sgnSel[1]),
        .op_a_i(opA[1]), .op_b_i(opB[1]),
        .rsp_valid_o(rspValid[1]), .rsp_ready_i(rspReady[1]),
        .rsp_data_o(rspData[1]), .rsp_sat_o(sat1)
    );

    // A watchdog stops the run if it stalls.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] getSat(input int u);
        return (u == 0) ? {3'b000, sat0} : sat1;
    endfunction

    // Reference model. It computes each lane with plain integer arithmetic on wide values.
    function automatic void refModel(input int lanes, input logic [1:0] opc, input logic sgn,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] acc,
                                     output logic [31:0] res, output logic [3:0] sat);
        int                 w;
        logic signed [127:0] m, va, vb, vc, s, lo, hi;
        logic [127:0]        t;
        w   = 32 / lanes;
        res = '0;
        sat = '0;
        m   = 1;
        m   = m << w;
        for (int k = 0; k < lanes; k++) begin
            va = (a >> (k * w)) & (m - 1);
            vb = (b >> (k * w)) & (m - 1);
            vc = (acc >> (k * w)) & (m - 1);
            if (sgn) begin
                if (va >= m / 2) va = va - m;
                if (vb >= m / 2) vb = vb - m;
                if (vc >= m / 2) vc = vc - m;
            end
            case (opc)
                2'b00:   s = vc + va * vb;
                2'b01:   s = vc - va * vb;
                2'b10:   s = 0;
                default: s = vc;
            endcase
            if (SatEn) begin
                lo = sgn ? -(m / 2) : 0;
                hi = sgn ? (m / 2 - 1) : (m - 1);
                if (s > hi) begin
                    s = hi;
                    sat[k] = 1'b1;
                end else if (s < lo) begin
                    s = lo;
                    sat[k] = 1'b1;
                end
            end
            t   = s & (m - 1);
            t   = t << (k * w);
            res = res | t[31:0];
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nMis++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Scoreboard step. It retires the handshaken responses and records the accepted requests.
    task automatic observe();
        exp_t        e;
        logic [31:0] r;
        logic [3:0]  s;
        for (int u = 0; u < 2; u++) begin
            if (rspValid[u] && rspReady[u]) begin
                if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                    checkOutput("unexpected response", 32'd1, 32'd0);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    checkOutput($sformatf("rsp data u%0d", u), rspData[u], e.d);
                    checkOutput($sformatf("rsp sat u%0d", u), {28'd0, getSat(u)}, {28'd0, e.s});
                    if (e.lat) checkOutput("latency", stepCnt - e.step, 32'd2);
                end
            end
            if (reqValid[u] && reqReady[u]) begin
                refModel((u == 0) ? 1 : 4, opSel[u], sgnSel[u], opA[u], opB[u],
                         modelAcc[u][accSel[u]], r, s);
                if (opSel[u] != 2'b11) modelAcc[u][accSel[u]] = r;
                e.d    = useTab ? tabD : r;
                e.s    = useTab ? tabS : s;
                e.step = stepCnt;
                e.lat  = latFlag;
                if (u == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // Drive one cycle of inputs on unit u. The other unit idles with rsp_ready high.
    task automatic applyStimulus(input int u, input bit v, input logic [1:0] o, input logic [1:0] sl,
                                 input logic sg, input logic [31:0] a, input logic [31:0] b,
                                 input logic rr, output bit accepted);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0;
            rspReady[i] = 1'b1;
        end
        reqValid[u] = v;
        opSel[u]    = o;
        accSel[u]   = sl;
        sgnSel[u]   = sg;
        opA[u]      = a;
        opB[u]      = b;
        rspReady[u] = rr;
        #2;
        stepCnt++;
        accepted = v && reqReady[u];
        observe();
    endtask

    task automatic drain();
        bit dummy;
        for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) begin
            applyStimulus(0, 1'b0, 2'b11, 2'd0, 1'b0, '0, '0, 1'b1, dummy);
        end
        checkOutput("drain", q0.size() + q1.size(), 32'd0);
    endtask

    task automatic clearModel();
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++)
            for (int j = 0; j < 4; j++) modelAcc[u][j] = '0;
    endtask

    function automatic vec_t mk(input int unit, input logic [1:0] op, input logic [1:0] sel,
                                input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] d, input logic [3:0] s);
        vec_t v;
        v.unit = unit; v.op = op; v.sel = sel; v.sgn = sgn;
        v.a = a; v.b = b; v.expD = d; v.expS = s;
        return v;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFFFFFF;
            1:       return 32'h80000000;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        tab [$];
        bit          acc;

        tab.push_back(mk(0, 2'b10, 2'd0, 1'b1, 32'd0,        32'd0, 32'd0,        4'd0));
        tab.push_back(mk(0, 2'b00, 2'd0, 1'b1, 32'd3,        32'd5, 32'd15,       4'd0));
        tab.push_back(mk(0, 2'b00, 2'd0, 1'b1, 32'hFFFFFFFE, 32'd4, 32'd7,        4'd0));
        tab.push_back(mk(0, 2'b11, 2'd0, 1'b1, 32'd0,        32'd0, 32'd7,        4'd0));
        tab.push_back(mk(0, 2'b10, 2'd1, 1'b1, 32'd0,        32'd0, 32'd0,        4'd0));
        tab.push_back(mk(0, 2'b00, 2'd1, 1'b1, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 4'd0));
        tab.push_back(mk(0, 2'b00, 2'd1, 1'b1, 32'd1,        32'd1,
                         SatEn ? 32'h7FFFFFFF : 32'h80000000, SatEn ? 4'd1 : 4'd0));
        tab.push_back(mk(0, 2'b01, 2'd3, 1'b0, 32'd2,        32'd3,
                         SatEn ? 32'h00000000 : 32'hFFFFFFFA, SatEn ? 4'd1 : 4'd0));
        tab.push_back(mk(1, 2'b00, 2'd0, 1'b0, 32'h02030405, 32'h01010102, 32'h0203040A, 4'd0));
        tab.push_back(mk(1, 2'b00, 2'd0, 1'b0, 32'h000000FF, 32'h000000FF,
                         SatEn ? 32'h020304FF : 32'h0203040B, SatEn ? 4'b0001 : 4'b0000));
        tab.push_back(mk(1, 2'b11, 2'd0, 1'b0, 32'd0,        32'd0,
                         SatEn ? 32'h020304FF : 32'h0203040B, 4'd0));
        tab.push_back(mk(1, 2'b10, 2'd2, 1'b1, 32'd0,        32'd0, 32'd0,        4'd0));
        tab.push_back(mk(1, 2'b01, 2'd2, 1'b1, 32'h7F808001, 32'h01010101,
                         SatEn ? 32'h817F7FFF : 32'h818080FF, SatEn ? 4'b0110 : 4'b0000));

        // The bench starts with reset asserted and all inputs idle.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0; rspReady[i] = 1'b1; opSel[i] = '0; accSel[i] = '0;
            sgnSel[i] = 1'b0; opA[i] = '0; opB[i] = '0;
        end
        clearModel();
        #3;
        for (int u = 0; u < 2; u++) begin
            checkOutput("reset rsp_valid", {31'd0, rspValid[u]}, 32'd0);
            checkOutput("reset rsp_data", rspData[u], 32'd0);
            checkOutput("reset rsp_sat", {28'd0, getSat(u)}, 32'd0);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("req_ready after reset", {31'd0, reqReady[0]}, 32'd1);

        // The table vectors run back to back with rsp_ready high, and latency is checked.
        $display("[TB] table vectors");
        useTab  = 1'b1;
        latFlag = 1'b1;
        foreach (tab[i]) begin
            tabD = tab[i].expD;
            tabS = tab[i].expS;
            applyStimulus(tab[i].unit, 1'b1, tab[i].op, tab[i].sel, tab[i].sgn,
                          tab[i].a, tab[i].b, 1'b1, acc);
            checkOutput("table accept", {31'd0, acc}, 32'd1);
        end
        drain();
        useTab  = 1'b0;
        latFlag = 1'b0;

        // Backpressure: rsp_ready stays low while three requests are issued.
        $display("[TB] backpressure sequence");
        applyStimulus(0, 1'b1, 2'b00, 2'd0, 1'b1, 32'd7, 32'd3, 1'b0, acc);
        checkOutput("bp accept A", {31'd0, acc}, 32'd1);
        applyStimulus(0, 1'b1, 2'b01, 2'd0, 1'b1, 32'd2, 32'd2, 1'b0, acc);
        checkOutput("bp accept B", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 2'b11, 2'd0, 1'b1, 32'd0, 32'd0, 1'b0, acc);
            checkOutput("bp req_ready low", {31'd0, reqReady[0]}, 32'd0);
            checkOutput("bp rsp_valid held", {31'd0, rspValid[0]}, 32'd1);
            checkOutput("bp rsp_data held", rspData[0], q0[0].d);
        end
        applyStimulus(0, 1'b1, 2'b11, 2'd0, 1'b1, 32'd0, 32'd0, 1'b1, acc);
        checkOutput("bp accept C on consume", {31'd0, acc}, 32'd1);
        drain();

        // Reset is asserted while two requests to acc2 are in flight.
        $display("[TB] reset mid-operation");
        applyStimulus(0, 1'b1, 2'b00, 2'd2, 1'b0, 32'd5, 32'd5, 1'b1, acc);
        applyStimulus(0, 1'b1, 2'b00, 2'd2, 1'b0, 32'd6, 32'd6, 1'b1, acc);
        @(negedge clock);
        reqValid[0] = 1'b0;
        #2;
        checkOutput("rsp_valid before reset", {31'd0, rspValid[0]}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rsp_valid drops in reset", {31'd0, rspValid[0]}, 32'd0);
        checkOutput("rsp_data cleared in reset", rspData[0], 32'd0);
        clearModel();
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("req_ready after mid reset", {31'd0, reqReady[0]}, 32'd1);
        useTab = 1'b1;
        tabD   = 32'd0;
        tabS   = 4'd0;
        applyStimulus(0, 1'b1, 2'b11, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, acc);
        checkOutput("rd acc2 accept", {31'd0, acc}, 32'd1);
        drain();
        useTab = 1'b0;

        // Random traffic on both units is checked against the reference model.
        $display("[TB] random traffic");
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 400; i++) begin
                applyStimulus(u, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                              pickOperand(), pickOperand(), ($urandom_range(0, 3) != 0), acc);
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
